// File: rtl/climate_pkg.sv
// Shared constants and types for the climate controller: ASCII command
// characters, mode encoding, decoded-command target codes and threshold
// defaults.
package climate_pkg;

  // ASCII characters used by the command protocol
  localparam logic [7:0] CHR_A = 8'h41;
  localparam logic [7:0] CHR_B = 8'h42;
  localparam logic [7:0] CHR_C = 8'h43;
  localparam logic [7:0] CHR_D = 8'h44;
  localparam logic [7:0] CHR_L = 8'h4C;
  localparam logic [7:0] CHR_0 = 8'h30;
  localparam logic [7:0] CHR_1 = 8'h31;
  localparam logic [7:0] CHR_9 = 8'h39;

  // Default thresholds and timing (1 MHz clock)
  localparam int unsigned DFLT_MAX_TEMP       = 30;
  localparam int unsigned DFLT_MIN_TEMP       = 10;
  localparam int unsigned DFLT_MAX_HUM        = 70;
  localparam int unsigned DFLT_MIN_HUM        = 40;
  localparam int unsigned DFLT_MIN_HOLD       = 2_000_000;
  localparam int unsigned DFLT_MANUAL_TIMEOUT = 60_000_000;

  // Control mode; this is also the state encoding of the mode FSM
  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_e;

  // Which register a decoded command addresses
  typedef enum logic [2:0] {
    TGT_MAXT = 3'd0,
    TGT_MINT = 3'd1,
    TGT_MAXH = 3'd2,
    TGT_MINH = 3'd3,
    TGT_LED  = 3'd4,
    TGT_NONE = 3'd7
  } tgt_e;

  // Result of decoding one framed command. valid covers the character
  // format only; ordering against the current bank is checked by the owner.
  typedef struct packed {
    tgt_e       tgt;
    logic [6:0] value;
    logic       fan;
    logic       hum;
    logic       valid;
  } cmd_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHR_0) && (c <= CHR_9);
  endfunction

  function automatic logic is_flag(input logic [7:0] c);
    return (c == CHR_0) || (c == CHR_1);
  endfunction

endpackage

// File: rtl/climate_cmd_decode.sv
// Combinational decoder: three ASCII characters -> {target, value, flags,
// format-valid}. Holds no state.
module climate_cmd_decode
  import climate_pkg::*;
(
  input  logic [7:0] chr_cmd,
  input  logic [7:0] chr_val0,
  input  logic [7:0] chr_val1,
  output cmd_t       cmd
);

  logic digits_ok;
  logic flags_ok;

  // Classify the command char and check the argument format it needs
  always_comb begin
    digits_ok = is_digit(chr_val0) && is_digit(chr_val1);
    flags_ok  = is_flag(chr_val0) && is_flag(chr_val1);

    cmd.tgt   = TGT_NONE;
    cmd.value = ({3'b000, chr_val0[3:0]} * 7'd10) + {3'b000, chr_val1[3:0]};
    cmd.fan   = chr_val0[0];
    cmd.hum   = chr_val1[0];
    cmd.valid = 1'b0;

    case (chr_cmd)
      CHR_A: begin cmd.tgt = TGT_MAXT; cmd.valid = digits_ok; end
      CHR_B: begin cmd.tgt = TGT_MINT; cmd.valid = digits_ok; end
      CHR_C: begin cmd.tgt = TGT_MAXH; cmd.valid = digits_ok; end
      CHR_D: begin cmd.tgt = TGT_MINH; cmd.valid = digits_ok; end
      CHR_L: begin cmd.tgt = TGT_LED;  cmd.valid = flags_ok;  end
      default: begin
        cmd.tgt   = TGT_NONE;
        cmd.valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/climate_ctrl.sv
// Climate controller: threshold bank, AUTO/MANUAL mode FSM, fan and
// humidifier control with per-actuator minimum hold time, and alarms.
// Optional feature macro: CLIMATE_HYST_EN (adds a hysteresis band on the
// actuator switch-off thresholds).
//
// Command handshake: a command is taken on the rising edge of rx_msg_done
// (level compared with its registered copy); exactly one of cfg_ack/cfg_err
// pulses for one cycle on the following edge, together with any register
// update. There is no backpressure.
// manual_mode is the mode FSM state register made visible.
module climate_ctrl
  import climate_pkg::*;
#(
  parameter int unsigned DEF_MAX_TEMP    = DFLT_MAX_TEMP,
  parameter int unsigned DEF_MIN_TEMP    = DFLT_MIN_TEMP,
  parameter int unsigned DEF_MAX_HUM     = DFLT_MAX_HUM,
  parameter int unsigned DEF_MIN_HUM     = DFLT_MIN_HUM,
  parameter int unsigned MIN_HOLD_CYCLES = DFLT_MIN_HOLD,
  parameter int unsigned MANUAL_TIMEOUT  = DFLT_MANUAL_TIMEOUT
`ifdef CLIMATE_HYST_EN
  ,
  parameter int unsigned HYST            = 2
`endif
)(
  input  logic       clk_1Mhz,
  input  logic       rst,
  input  logic [7:0] chr_cmd,
  input  logic [7:0] chr_val0,
  input  logic [7:0] chr_val1,
  input  logic       rx_msg_done,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       data_valid,
  output logic [6:0] max_temp,
  output logic [6:0] min_temp,
  output logic [6:0] max_hum,
  output logic [6:0] min_hum,
  output logic       fan_state,
  output logic       hum_state,
  output logic       manual_mode,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       alarm_temp,
  output logic       alarm_hum
);

  localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);
  localparam int TMR_W  = (MANUAL_TIMEOUT > 1) ? $clog2(MANUAL_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(MANUAL_TIMEOUT - 1);

  cmd_t              dec;
  logic              rx_done_q;
  logic              strobe;
  logic              cmd_ok;
  logic              led_load;
  mode_e             mode_q;
  mode_e             mode_d;
  logic [TMR_W-1:0]  timer_q;
  logic [HOLD_W-1:0] hold_fan_q;
  logic [HOLD_W-1:0] hold_hum_q;
  logic              auto_eval;
  logic              fan_d;
  logic              hum_d;
  logic [7:0]        fan_off_thr;
  logic [7:0]        hum_off_thr;

  climate_cmd_decode u_decode (
    .chr_cmd  (chr_cmd),
    .chr_val0 (chr_val0),
    .chr_val1 (chr_val1),
    .cmd      (dec)
  );

  // Track the framing level; during reset it follows the input so a level
  // already high when reset releases is not seen as a new command
  always_ff @(posedge clk_1Mhz) begin
    rx_done_q <= rx_msg_done;
  end

  assign strobe = rx_msg_done & ~rx_done_q;

  // Accept a well-formed command only if the bank keeps min < max
  always_comb begin
    cmd_ok = 1'b0;
    if (dec.valid) begin
      case (dec.tgt)
        TGT_MAXT: cmd_ok = min_temp < dec.value;
        TGT_MINT: cmd_ok = dec.value < max_temp;
        TGT_MAXH: cmd_ok = min_hum < dec.value;
        TGT_MINH: cmd_ok = dec.value < max_hum;
        TGT_LED:  cmd_ok = 1'b1;
        default:  cmd_ok = 1'b0;
      endcase
    end
  end

  assign led_load = strobe & cmd_ok & (dec.tgt == TGT_LED);

  // Threshold bank and command response pulses
  always_ff @(posedge clk_1Mhz) begin
    if (rst) begin
      max_temp <= 7'(DEF_MAX_TEMP);
      min_temp <= 7'(DEF_MIN_TEMP);
      max_hum  <= 7'(DEF_MAX_HUM);
      min_hum  <= 7'(DEF_MIN_HUM);
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_ack <= strobe & cmd_ok;
      cfg_err <= strobe & ~cmd_ok;
      if (strobe && cmd_ok) begin
        case (dec.tgt)
          TGT_MAXT: max_temp <= dec.value;
          TGT_MINT: min_temp <= dec.value;
          TGT_MAXH: max_hum  <= dec.value;
          TGT_MINH: min_hum  <= dec.value;
          default:  ;
        endcase
      end
    end
  end

  // Mode FSM state register
  always_ff @(posedge clk_1Mhz) begin
    if (rst) mode_q <= MODE_AUTO;
    else     mode_q <= mode_d;
  end

  // Mode FSM next state: a valid 'L' enters or reloads MANUAL; the timeout
  // returns to AUTO
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_AUTO: begin
        if (led_load) mode_d = MODE_MANUAL;
      end
      MODE_MANUAL: begin
        if (led_load)                mode_d = MODE_MANUAL;
        else if (timer_q == TMR_LAST) mode_d = MODE_AUTO;
      end
      default: mode_d = MODE_AUTO;
    endcase
  end

  assign manual_mode = (mode_q == MODE_MANUAL);

  // MANUAL residence timer; restarts on every accepted 'L'
  always_ff @(posedge clk_1Mhz) begin
    if (rst || led_load || (mode_d != MODE_MANUAL)) timer_q <= '0;
    else                                             timer_q <= timer_q + TMR_W'(1);
  end

  // Switch-off thresholds, optionally widened by the hysteresis band
`ifdef CLIMATE_HYST_EN
  logic [8:0] hum_sum;
  always_comb begin
    hum_sum     = {2'b00, min_hum} + 9'(HYST);
    hum_off_thr = (hum_sum > 9'd99) ? 8'd99 : hum_sum[7:0];
    fan_off_thr = ({1'b0, max_temp} >= 8'(HYST)) ? ({1'b0, max_temp} - 8'(HYST)) : 8'd0;
  end
`else
  assign fan_off_thr = {1'b0, max_temp};
  assign hum_off_thr = {1'b0, min_hum};
`endif

  assign auto_eval = (mode_q == MODE_AUTO) && data_valid;

  // Next actuator values: 'L' forces them; AUTO acts only on a sample and
  // only once the actuator's hold time has elapsed (blocked toggles drop)
  always_comb begin
    fan_d = fan_state;
    hum_d = hum_state;
    if (led_load) begin
      fan_d = dec.fan;
      hum_d = dec.hum;
    end else if (auto_eval) begin
      if (hold_fan_q == HOLD_MAX) begin
        if (!fan_state && (temperature > {1'b0, max_temp})) fan_d = 1'b1;
        else if (fan_state && (temperature <= fan_off_thr)) fan_d = 1'b0;
      end
      if (hold_hum_q == HOLD_MAX) begin
        if (!hum_state && (humidity < {1'b0, min_hum}))  hum_d = 1'b1;
        else if (hum_state && (humidity >= hum_off_thr)) hum_d = 1'b0;
      end
    end
  end

  // Actuator registers and their saturating hold counters
  always_ff @(posedge clk_1Mhz) begin
    if (rst) begin
      fan_state  <= 1'b0;
      hum_state  <= 1'b0;
      hold_fan_q <= '0;
      hold_hum_q <= '0;
    end else begin
      fan_state <= fan_d;
      hum_state <= hum_d;
      if (fan_d != fan_state)      hold_fan_q <= '0;
      else if (hold_fan_q != HOLD_MAX) hold_fan_q <= hold_fan_q + HOLD_W'(1);
      if (hum_d != hum_state)      hold_hum_q <= '0;
      else if (hold_hum_q != HOLD_MAX) hold_hum_q <= hold_hum_q + HOLD_W'(1);
    end
  end

  // Alarms follow every sample in both modes, against the pre-edge bank
  always_ff @(posedge clk_1Mhz) begin
    if (rst) begin
      alarm_temp <= 1'b0;
      alarm_hum  <= 1'b0;
    end else if (data_valid) begin
      alarm_temp <= temperature < {1'b0, min_temp};
      alarm_hum  <= humidity > {1'b0, max_hum};
    end
  end

endmodule

// File: tb/tb_climate_ctrl.sv
// Bench for climate_ctrl: directed commands and samples with hand-computed
// expectations pushed into queues; a monitor pops and compares whenever the
// DUT answers a command (cfg_ack/cfg_err) or has taken a sample.
module tb_climate_ctrl;

  localparam int HOLD = 20;
  localparam int MTO  = 50;
  localparam int CW   = 33;
  localparam int SW   = 4;
`ifdef CLIMATE_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  // Clock / reset
  logic clk_1Mhz = 1'b0;
  always #5 clk_1Mhz = ~clk_1Mhz;

  logic       rst;
  logic [7:0] chr_cmd, chr_val0, chr_val1;
  logic       rx_msg_done;
  logic [7:0] temperature, humidity;
  logic       data_valid;
  logic [6:0] max_temp, min_temp, max_hum, min_hum;
  logic       fan_state, hum_state, manual_mode, cfg_ack, cfg_err;
  logic       alarm_temp, alarm_hum;

  climate_ctrl #(
    .MIN_HOLD_CYCLES (HOLD),
    .MANUAL_TIMEOUT  (MTO)
  ) dut (
    .clk_1Mhz    (clk_1Mhz),
    .rst         (rst),
    .chr_cmd     (chr_cmd),
    .chr_val0    (chr_val0),
    .chr_val1    (chr_val1),
    .rx_msg_done (rx_msg_done),
    .temperature (temperature),
    .humidity    (humidity),
    .data_valid  (data_valid),
    .max_temp    (max_temp),
    .min_temp    (min_temp),
    .max_hum     (max_hum),
    .min_hum     (min_hum),
    .fan_state   (fan_state),
    .hum_state   (hum_state),
    .manual_mode (manual_mode),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .alarm_temp  (alarm_temp),
    .alarm_hum   (alarm_hum)
  );

  // Scoreboard state
  logic [CW-1:0] exp_q[$];
  logic [SW-1:0] smp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic dv_cap;
  logic man_prev;
  int man_rise = 0;
  int man_fall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cw(input logic ack, input logic err,
                                       input int mxt, input int mnt, input int mxh, input int mnh,
                                       input logic man, input logic fan, input logic hum);
    return {ack, err, 7'(mxt), 7'(mnt), 7'(mxh), 7'(mnh), man, fan, hum};
  endfunction

  always @(posedge clk_1Mhz) cyc <= cyc + 1;
  always @(posedge clk_1Mhz) dv_cap <= data_valid;

  // Record when MANUAL starts and ends
  always @(posedge clk_1Mhz) begin
    #1;
    if (manual_mode === 1'b1 && man_prev !== 1'b1) man_rise = cyc;
    if (manual_mode === 1'b0 && man_prev === 1'b1) man_fall = cyc;
    man_prev = manual_mode;
  end

  // Monitor: compare every DUT response against the queued expectation
  initial begin : monitor
    logic [CW-1:0] exp_c;
    logic [SW-1:0] exp_s;
    forever begin
      @(posedge clk_1Mhz);
      #1;
      if (cfg_ack === 1'b1 || cfg_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", {cfg_ack, cfg_err}, 2'b00);
        end else begin
          exp_c = exp_q.pop_front();
          check("cmd_resp", {cfg_ack, cfg_err, max_temp, min_temp, max_hum, min_hum,
                             manual_mode, fan_state, hum_state}, exp_c);
        end
      end
      if (dv_cap === 1'b1) begin
        if (smp_q.size() == 0) begin
          check("smp_unexpected", 1'b1, 1'b0);
        end else begin
          exp_s = smp_q.pop_front();
          check("smp_resp", {fan_state, hum_state, alarm_temp, alarm_hum}, exp_s);
        end
      end
    end
  end

  // Driver tasks (entered and left 2 time units after a rising edge)
  task automatic tick(input int n);
    repeat (n) @(posedge clk_1Mhz);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] v0, input logic [7:0] v1,
                          input int hold, input logic [CW-1:0] exp);
    exp_q.push_back(exp);
    chr_cmd = c; chr_val0 = v0; chr_val1 = v1;
    rx_msg_done = 1'b1;
    tick(hold);
    rx_msg_done = 1'b0;
    tick(1);
  endtask

  task automatic sample(input int t, input int h, input logic [SW-1:0] exp);
    smp_q.push_back(exp);
    temperature = 8'(t); humidity = 8'(h);
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    tick(1);
  endtask

  task automatic cmd_and_sample(input logic [7:0] c, input logic [7:0] v0, input logic [7:0] v1,
                                input int t, input int h,
                                input logic [CW-1:0] exp_c, input logic [SW-1:0] exp_s);
    exp_q.push_back(exp_c);
    smp_q.push_back(exp_s);
    chr_cmd = c; chr_val0 = v0; chr_val1 = v1;
    temperature = 8'(t); humidity = 8'(h);
    rx_msg_done = 1'b1;
    data_valid = 1'b1;
    tick(1);
    rx_msg_done = 1'b0;
    data_valid = 1'b0;
    tick(1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    rx_msg_done = 1'b1;              // framed during reset: must be lost
    chr_cmd = "A"; chr_val0 = "3"; chr_val1 = "5";
    temperature = 8'd0; humidity = 8'd0; data_valid = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);

    check("rst_max_temp", max_temp, 30);
    check("rst_min_temp", min_temp, 10);
    check("rst_max_hum", max_hum, 70);
    check("rst_min_hum", min_hum, 40);
    check("rst_flags", {fan_state, hum_state, manual_mode, cfg_ack, cfg_err, alarm_temp, alarm_hum}, 7'b0);
    rx_msg_done = 1'b0;
    tick(2);

    // Threshold commands; held level must give only one response
    send_cmd("A", "3", "5", 10, cw(1, 0, 35, 10, 70, 40, 0, 0, 0));
    send_cmd("B", "X", "0", 1,  cw(0, 1, 35, 10, 70, 40, 0, 0, 0));
    send_cmd("B", "4", "0", 1,  cw(0, 1, 35, 10, 70, 40, 0, 0, 0));
    send_cmd("A", "0", "9", 1,  cw(0, 1, 35, 10, 70, 40, 0, 0, 0));
    send_cmd("A", "3", "0", 1,  cw(1, 0, 30, 10, 70, 40, 0, 0, 0));
    send_cmd("Z", "1", "1", 1,  cw(0, 1, 30, 10, 70, 40, 0, 0, 0));
    send_cmd("L", "2", "0", 1,  cw(0, 1, 30, 10, 70, 40, 0, 0, 0));
    send_cmd("C", "9", "A", 1,  cw(0, 1, 30, 10, 70, 40, 0, 0, 0));
    tick(25);

    // AUTO fan: on above max_temp, hold blocks early off, then off
    sample(31, 50, 4'b1000);
    tick(2);
    sample(20, 50, 4'b1000);
    tick(25);
    sample(29, 50, HYST_ON ? 4'b1000 : 4'b0000);
    tick(25);
    sample(28, 50, 4'b0000);
    tick(25);

    // AUTO humidifier plus low-temperature alarm
    sample(5, 39, 4'b0110);
    tick(25);
    sample(20, 41, HYST_ON ? 4'b0100 : 4'b0000);
    tick(25);
    sample(20, 42, 4'b0000);
    tick(25);

    // MANUAL override, samples ignored for control but alarms update
    send_cmd("L", "1", "0", 1, cw(1, 0, 30, 10, 70, 40, 1, 1, 0));
    sample(5, 90, 4'b1011);
    check("manual_active", manual_mode, 1'b1);
    for (int i = 0; i < 200 && manual_mode !== 1'b0; i++) tick(1);
    check("manual_exit", manual_mode, 1'b0);
    check("manual_len", man_fall - man_rise, MTO);
    check("auto_reentry_fan_kept", fan_state, 1'b1);
    sample(20, 50, 4'b0000);

    // Command and sample on the same edge: sample sees the old max_hum
    cmd_and_sample("C", "5", "0", 20, 60, cw(1, 0, 30, 10, 50, 40, 0, 0, 0), 4'b0000);
    tick(2);
    sample(20, 60, 4'b0001);
    send_cmd("D", "6", "0", 1, cw(0, 1, 30, 10, 50, 40, 0, 0, 0));
    send_cmd("D", "4", "9", 1, cw(1, 0, 30, 10, 50, 49, 0, 0, 0));
    tick(5);

    check("cmd_q_drained", exp_q.size(), 0);
    check("smp_q_drained", smp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
